// File: rtl/cart_ram_pkg.sv
// Shared definitions for cart_ram_arbiter: FSM state codes, uC address-port selects
// and the parameter legality check.
package cart_ram_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CART_RD = 3'd1;
  localparam logic [2:0] ST_CART_WR = 3'd2;
  localparam logic [2:0] ST_UC_RD   = 3'd3;
  localparam logic [2:0] ST_UC_WR   = 3'd4;

  localparam logic [1:0] SEL_LO  = 2'd0;
  localparam logic [1:0] SEL_MID = 2'd1;
  localparam logic [1:0] SEL_HI  = 2'd2;
  localparam logic [1:0] SEL_INC = 2'd3;

  function automatic bit params_legal(int addr_w, int access_cycles);
    return (addr_w >= 14) && (addr_w <= 21) && (access_cycles >= 3) && (access_cycles <= 8);
  endfunction

endpackage

// File: rtl/cart_ram_arbiter_if.sv
// uC-side request/acknowledge and address-port strobe of cart_ram_arbiter.
interface cart_ram_arbiter_if;

  logic       uc_read;
  logic       uc_write;
  logic       uc_ack;
  logic [1:0] uc_addr_sel;
  logic       strobe_addr;

  modport master (output uc_read, uc_write, uc_addr_sel, strobe_addr, input uc_ack);
  modport slave  (input uc_read, uc_write, uc_addr_sel, strobe_addr, output uc_ack);

endinterface

// File: rtl/cart_ram_arbiter_fi2_edge_sync.sv
// Two-flop synchroniser plus edge register; rise/fall pulses last one clk and
// appear 2 clk after the pin changes, so the consuming state changes on the 3rd edge.
module fi2_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [2:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= 3'b000;
    else     sr <= {sr[1:0], din};
  end

  assign rise = sr[1] & ~sr[2];
  assign fall = ~sr[1] & sr[2];

endmodule

// File: rtl/cart_ram_arbiter.sv
// Shares one async SRAM between the Atari cart bus and a uC port; cart wins by starting on
// phi2 rise. CART_RAM_WRITE_EN enables cart writes, otherwise the cart window is ROM-only.
module cart_ram_arbiter
  import cart_ram_pkg::*;
#(
  parameter int ADDR_W        = 17,
  parameter int ACCESS_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fi2,
  input  logic              cart_s4,
  input  logic              cart_s5,
  input  logic              cart_cctl,
  input  logic              cart_rw,
  input  logic [12:0]       cart_addr,
  inout  wire  [7:0]        cart_data,
  output logic              ram_oe,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [7:0]        ram_data,
  inout  wire  [7:0]        uc_data,
  cart_ram_arbiter_if.slave uc
);

  localparam int         BANK_W = ADDR_W - 13;
  localparam logic [2:0] LAST   = 3'(ACCESS_CYCLES - 1);
  localparam logic [2:0] LATCH  = 3'(ACCESS_CYCLES - 2);

  if (!params_legal(ADDR_W, ACCESS_CYCLES)) begin : g_bad_params
    $error("cart_ram_arbiter: ADDR_W or ACCESS_CYCLES out of range");
  end

  logic              fi2_rise, fi2_fall, stb_rise, stb_fall_unused;
  logic [2:0]        state, phase;
  logic [BANK_W-1:0] bank;
  logic              cart_en, cart_sel, cart_wr_ok;
  logic              uc_busy, rd_st, wr_st;
  logic [7:0]        cart_latch, uc_latch, pend_dat;
  logic [1:0]        pend_sel;
  logic              pend;
  logic [ADDR_W-1:0] uc_addr, uc_addr_nxt;
  logic [23:0]       cur_ext;

`ifdef CART_RAM_WRITE_EN
  assign cart_wr_ok = 1'b1;
`else
  assign cart_wr_ok = 1'b0;
`endif

  fi2_edge_sync u_fi2_sync (.clk(clk), .rst(rst), .din(fi2), .rise(fi2_rise), .fall(fi2_fall));
  fi2_edge_sync u_stb_sync (.clk(clk), .rst(rst), .din(uc.strobe_addr), .rise(stb_rise),
                            .fall(stb_fall_unused));

  assign cart_sel = cart_en & (cart_s4 ^ cart_s5);
  assign uc_busy  = (state == ST_UC_RD) || (state == ST_UC_WR);
  assign rd_st    = (state == ST_CART_RD) || (state == ST_UC_RD);
  assign wr_st    = (state == ST_CART_WR) || (state == ST_UC_WR);

  // Strobes decode straight from async-reset state so reset releases the SRAM without a clock.
  assign ram_oe = ~rd_st;
  assign ram_we = ~(wr_st && (phase >= 3'd1) && (phase <= LATCH));

  always_comb begin
    ram_addr = uc_addr;
    if ((state == ST_CART_RD) || (state == ST_CART_WR))
      ram_addr = cart_s4 ? {bank, cart_addr} : {{BANK_W{1'b0}}, cart_addr};
  end

  assign cart_data = (cart_sel & cart_rw) ? cart_latch : 8'bz;
  assign uc_data   = uc.uc_read ? uc_latch : 8'bz;
  assign ram_data  = (state == ST_CART_WR) ? cart_data :
                     (state == ST_UC_WR)   ? uc_data   : 8'bz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      phase      <= 3'd0;
      bank       <= '0;
      cart_en    <= 1'b1;
      cart_latch <= 8'h00;
      uc_latch   <= 8'h00;
    end else if (state == ST_IDLE) begin
      phase <= 3'd0;
      if (fi2_rise) begin
        if (cart_sel) begin
          if (cart_rw)         state <= ST_CART_RD;
          else if (cart_wr_ok) state <= ST_CART_WR;
        end else if (!cart_cctl && !cart_rw) begin
          bank    <= cart_addr[BANK_W-1:0];
          cart_en <= ~cart_addr[7];
        end
      end else if (fi2_fall && !uc.uc_ack) begin
        if (uc.uc_write)     state <= ST_UC_WR;
        else if (uc.uc_read) state <= ST_UC_RD;
      end
    end else begin
      if ((phase == LATCH) && (state == ST_CART_RD)) cart_latch <= ram_data;
      if ((phase == LATCH) && (state == ST_UC_RD))   uc_latch   <= ram_data;
      if (phase == LAST) begin
        state <= ST_IDLE;
        phase <= 3'd0;
      end else begin
        phase <= phase + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              uc.uc_ack <= 1'b0;
    else if (uc_busy && (phase == LAST))  uc.uc_ack <= 1'b1;
    else if (!uc.uc_read && !uc.uc_write) uc.uc_ack <= 1'b0;
  end

  assign cur_ext = 24'(uc_addr);

  always_comb begin
    case (pend_sel)
      SEL_LO:  uc_addr_nxt = ADDR_W'({cur_ext[23:8], pend_dat});
      SEL_MID: uc_addr_nxt = ADDR_W'({cur_ext[23:16], pend_dat, cur_ext[7:0]});
      SEL_HI:  uc_addr_nxt = ADDR_W'({pend_dat, cur_ext[15:0]});
      default: uc_addr_nxt = uc_addr + ADDR_W'(1);
    endcase
  end

  // A strobe is parked until no uC access is using uc_addr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= 1'b0;
      pend_sel <= 2'd0;
      pend_dat <= 8'h00;
      uc_addr  <= '0;
    end else if (stb_rise) begin
      pend     <= 1'b1;
      pend_sel <= uc.uc_addr_sel;
      pend_dat <= uc_data;
    end else if (pend && !uc_busy) begin
      pend    <= 1'b0;
      uc_addr <= uc_addr_nxt;
    end
  end

endmodule
